// File: rtl/fetch_prefetch_buffer_if.sv
// Fetch-stage bundle: instruction-memory request/response, redirect from execute,
// and the head-of-queue view presented to decode.
interface fetch_prefetch_buffer_if;
  logic        memReq;
  logic [31:0] memAddr;
  logic        memAck;
  logic [31:0] memData;
  logic        redirect;
  logic [31:0] redirectPC;
  logic        stallF;
  logic [31:0] instrF;
  logic [31:0] PCF;
  logic [31:0] PCPlus4F;
  logic        validF;

  modport master (
    output memReq, memAddr, instrF, PCF, PCPlus4F, validF,
    input  memAck, memData, redirect, redirectPC, stallF
  );

  modport slave (
    input  memReq, memAddr, instrF, PCF, PCPlus4F, validF,
    output memAck, memData, redirect, redirectPC, stallF
  );
endinterface

// File: rtl/fetch_prefetch_buffer.sv
// Instruction prefetch queue: one-outstanding-request fetch FSM feeding a circular
// buffer of {PC, instruction} pairs, flushed and retargeted on redirect.
module fetch_prefetch_buffer #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'd0
) (
  input logic                    clk,
  input logic                    rst,
  fetch_prefetch_buffer_if.master bus
);
  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam logic [CntW-1:0] Full = CntW'(DEPTH);
  localparam logic [31:0] Nop = 32'h0000_0013;

  typedef enum logic [1:0] {StIdle, StReq, StDiscard} state_e;

  state_e          state_q, state_d;
  logic [31:0]     fetch_pc_q, fetch_pc_d;
  logic            mem_req_q, mem_req_d;
  logic [31:0]     mem_addr_q, mem_addr_d;
  logic [PtrW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CntW-1:0] count_q, count_d;
  logic [31:0]     pc_mem    [DEPTH];
  logic [31:0]     instr_mem [DEPTH];
  logic            valid, push, pop;

  assign valid = (count_q != '0);
  // Redirect wins over both queue operations in the same cycle.
  assign pop   = valid && !bus.stallF && !bus.redirect;
  assign push  = (state_q == StReq) && bus.memAck && !bus.redirect;

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    mem_req_d  = mem_req_q;
    mem_addr_d = mem_addr_q;
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q + CntW'(push) - CntW'(pop);
    if (push) tail_d = tail_q + PtrW'(1);
    if (pop)  head_d = head_q + PtrW'(1);

    if (bus.redirect) begin
      fetch_pc_d = {bus.redirectPC[31:2], 2'b00};
      mem_req_d  = 1'b0;
      head_d     = '0;
      tail_d     = '0;
      count_d    = '0;
      unique case (state_q)
        StReq:     state_d = bus.memAck ? StIdle : StDiscard;
        StDiscard: if (bus.memAck) state_d = StIdle;
        default:   state_d = state_q;
      endcase
    end else begin
      unique case (state_q)
        StIdle: begin
          // Nothing is outstanding here, so the occupancy alone gates issue.
          if (count_q < Full) begin
            state_d    = StReq;
            mem_req_d  = 1'b1;
            mem_addr_d = fetch_pc_q;
          end
        end
        StReq: begin
          if (bus.memAck) begin
            fetch_pc_d = mem_addr_q + 32'd4;
            if (count_d < Full) begin
              mem_addr_d = mem_addr_q + 32'd4;
            end else begin
              state_d   = StIdle;
              mem_req_d = 1'b0;
            end
          end
        end
        StDiscard: if (bus.memAck) state_d = StIdle;
        default:   state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      fetch_pc_q <= RESET_PC;
      mem_req_q  <= 1'b0;
      mem_addr_q <= RESET_PC;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[tail_q]    <= mem_addr_q;
      instr_mem[tail_q] <= bus.memData;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) assert (!(push && count_q == Full));
  end

  assign bus.memReq   = mem_req_q;
  assign bus.memAddr  = mem_addr_q;
  assign bus.validF   = valid;
  assign bus.instrF   = valid ? instr_mem[head_q] : Nop;
  assign bus.PCF      = valid ? pc_mem[head_q] : fetch_pc_q;
  assign bus.PCPlus4F = bus.PCF + 32'd4;
endmodule

// File: tb/tb_fetch_prefetch_buffer.sv
// Directed bench for fetch_prefetch_buffer (DEPTH=4, RESET_PC=0): streaming, full-queue
// stall, redirect flush/discard, simultaneous push+pop, address wrap and reset.
module tb_fetch_prefetch_buffer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;

  fetch_prefetch_buffer_if bus ();

  fetch_prefetch_buffer #(.DEPTH(4), .RESET_PC(32'd0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    bus.memAck     = 1'b0;
    bus.memData    = 32'h0;
    bus.redirect   = 1'b0;
    bus.redirectPC = 32'h0;
    bus.stallF     = 1'b0;

    // Reset state, with an ack arriving during reset that must be ignored.
    tick(); tick();
    check("rst_memReq", {31'b0, bus.memReq}, 32'd0);
    check("rst_memAddr", bus.memAddr, 32'h0);
    check("rst_validF", {31'b0, bus.validF}, 32'd0);
    check("rst_instrF", bus.instrF, 32'h13);
    check("rst_PCF", bus.PCF, 32'h0);
    check("rst_PCPlus4F", bus.PCPlus4F, 32'h4);
    bus.memAck = 1'b1;
    bus.memData = 32'hBAD0_0000;
    tick();
    check("rst_ack_validF", {31'b0, bus.validF}, 32'd0);

    // Zero-wait streaming.
    rst = 1'b0;
    check("rel_memReq", {31'b0, bus.memReq}, 32'd0);
    tick();
    check("s1_memReq", {31'b0, bus.memReq}, 32'd1);
    check("s1_memAddr", bus.memAddr, 32'h0);
    check("s1_validF", {31'b0, bus.validF}, 32'd0);
    bus.memData = 32'h0100_0000;
    tick();
    check("s2_validF", {31'b0, bus.validF}, 32'd1);
    check("s2_PCF", bus.PCF, 32'h0);
    check("s2_instrF", bus.instrF, 32'h0100_0000);
    check("s2_PCPlus4F", bus.PCPlus4F, 32'h4);
    check("s2_memAddr", bus.memAddr, 32'h4);
    bus.memData = 32'h0100_0004;
    tick();
    check("s3_PCF", bus.PCF, 32'h4);
    check("s3_instrF", bus.instrF, 32'h0100_0004);
    bus.memData = 32'h0100_0008;
    tick();
    check("s4_PCF", bus.PCF, 32'h8);
    check("s4_memReq", {31'b0, bus.memReq}, 32'd1);

    // Reset pulsed mid-request: asynchronous clear, then restart at RESET_PC.
    rst = 1'b1;
    #1;
    check("ar_memReq", {31'b0, bus.memReq}, 32'd0);
    check("ar_validF", {31'b0, bus.validF}, 32'd0);
    check("ar_memAddr", bus.memAddr, 32'h0);
    tick();
    bus.stallF = 1'b1;
    rst = 1'b0;
    check("ar_rel_memReq", {31'b0, bus.memReq}, 32'd0);
    tick();
    check("f1_memReq", {31'b0, bus.memReq}, 32'd1);
    check("f1_memAddr", bus.memAddr, 32'h0);
    check("f1_validF", {31'b0, bus.validF}, 32'd0);

    // Stalled fill: exactly four pushes, then memReq drops.
    bus.memData = 32'h0200_0000;
    tick();
    check("f2_PCF", bus.PCF, 32'h0);
    check("f2_instrF", bus.instrF, 32'h0200_0000);
    bus.memData = 32'h0200_0004;
    tick();
    bus.memData = 32'h0200_0008;
    tick();
    check("f4_memReq", {31'b0, bus.memReq}, 32'd1);
    bus.memData = 32'h0200_000C;
    tick();
    check("f5_memReq", {31'b0, bus.memReq}, 32'd0);
    check("f5_PCF", bus.PCF, 32'h0);
    tick();
    check("f6_memReq", {31'b0, bus.memReq}, 32'd0);
    bus.stallF = 1'b0;
    tick();
    check("f7_PCF", bus.PCF, 32'h4);
    check("f7_memReq", {31'b0, bus.memReq}, 32'd0);
    bus.stallF = 1'b1;
    tick();
    check("f8_memReq", {31'b0, bus.memReq}, 32'd1);
    check("f8_memAddr", bus.memAddr, 32'h10);
    check("f8_PCF", bus.PCF, 32'h4);

    // Push and pop together at count=3, then drain to confirm order.
    bus.stallF = 1'b0;
    bus.memData = 32'h0200_0010;
    tick();
    check("f9_PCF", bus.PCF, 32'h8);
    check("f9_memAddr", bus.memAddr, 32'h14);
    bus.memAck = 1'b0;
    tick();
    check("f10_PCF", bus.PCF, 32'hC);
    check("f10_instrF", bus.instrF, 32'h0200_000C);
    tick();
    check("f11_PCF", bus.PCF, 32'h10);
    check("f11_instrF", bus.instrF, 32'h0200_0010);
    tick();
    check("f12_validF", {31'b0, bus.validF}, 32'd0);
    check("f12_PCF", bus.PCF, 32'h14);
    check("f12_instrF", bus.instrF, 32'h13);
    check("f12_memAddr_held", bus.memAddr, 32'h14);
    check("f12_memReq_held", {31'b0, bus.memReq}, 32'd1);

    // Redirect coinciding with an ack: data dropped, target aligned.
    bus.redirect = 1'b1;
    bus.redirectPC = 32'h102;
    bus.memAck = 1'b1;
    bus.memData = 32'hDEAD_DEAD;
    tick();
    check("r1_memReq", {31'b0, bus.memReq}, 32'd0);
    check("r1_validF", {31'b0, bus.validF}, 32'd0);
    check("r1_PCF", bus.PCF, 32'h100);
    bus.redirect = 1'b0;
    bus.memAck = 1'b0;
    tick();
    check("r2_memReq", {31'b0, bus.memReq}, 32'd1);
    check("r2_memAddr", bus.memAddr, 32'h100);

    // Redirect one cycle after memReq rises; the late ack must be discarded.
    bus.redirect = 1'b1;
    bus.redirectPC = 32'h40;
    tick();
    check("d1_memReq", {31'b0, bus.memReq}, 32'd0);
    check("d1_PCF", bus.PCF, 32'h40);
    bus.redirect = 1'b0;
    tick();
    check("d2_memReq", {31'b0, bus.memReq}, 32'd0);
    bus.memAck = 1'b1;
    bus.memData = 32'hBAD0_0100;
    tick();
    check("d3_validF", {31'b0, bus.validF}, 32'd0);
    check("d3_memReq", {31'b0, bus.memReq}, 32'd0);
    bus.memAck = 1'b0;
    tick();
    check("d4_memReq", {31'b0, bus.memReq}, 32'd1);
    check("d4_memAddr", bus.memAddr, 32'h40);
    check("d4_validF", {31'b0, bus.validF}, 32'd0);
    bus.memAck = 1'b1;
    bus.memData = 32'h0300_0040;
    tick();
    check("d5_validF", {31'b0, bus.validF}, 32'd1);
    check("d5_PCF", bus.PCF, 32'h40);
    check("d5_instrF", bus.instrF, 32'h0300_0040);
    bus.memAck = 1'b0;

    // Redirect flushes a non-empty queue; fetch at the top of memory wraps to 0.
    bus.redirect = 1'b1;
    bus.redirectPC = 32'hFFFF_FFFF;
    tick();
    check("w1_validF", {31'b0, bus.validF}, 32'd0);
    check("w1_PCF", bus.PCF, 32'hFFFF_FFFC);
    check("w1_PCPlus4F", bus.PCPlus4F, 32'h0);
    bus.redirect = 1'b0;
    bus.memAck = 1'b1;
    bus.memData = 32'hBAD0_0044;
    tick();
    check("w2_memReq", {31'b0, bus.memReq}, 32'd0);
    tick();
    check("w3_memAddr", bus.memAddr, 32'hFFFF_FFFC);
    bus.stallF = 1'b1;
    bus.memData = 32'h0400_FFFC;
    tick();
    check("w4_PCF", bus.PCF, 32'hFFFF_FFFC);
    check("w4_instrF", bus.instrF, 32'h0400_FFFC);
    check("w4_PCPlus4F", bus.PCPlus4F, 32'h0);
    check("w4_memAddr", bus.memAddr, 32'h0);
    bus.memAck = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
